// File: rtl/sipo_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | sipo_ctrl_pkg : shared FSM states and defaults for the SIPO ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STOP  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/shift_reg_sipo.sv
// +--------------------------------------------------------------------+
// | shift_reg_sipo : serial-in/parallel-out register, first bit -> MSB |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module shift_reg_sipo
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_ser,
  output logic [WIDTH-1:0] o_po
);

  logic [WIDTH-1:0] r_po;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_po <= '0;
    end else if (i_en) begin
      r_po <= {r_po[WIDTH-2:0], i_ser};
    end
  end

  assign o_po = r_po;

endmodule

`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
// +--------------------------------------------------------------------+
// | sipo_frame_ctrl : start/stop framing, SIPO enable, valid/ready hold|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ser_in,
  input  logic             i_frame_en,
  output logic             o_shift_en,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_frame_err,
  output logic             o_overrun
);

  localparam int              CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_po;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_consume;

  shift_reg_sipo #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_shift_en),
    .i_ser (i_ser_in),
    .o_po  (w_po)
  );

  assign w_consume = r_valid & i_data_ready;

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_frame_en && !i_ser_in) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift_en = 1'b1;
        if (r_cnt == C_CNT_LAST) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != S_IDLE);
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end

      if (w_consume) begin
        r_valid <= 1'b0;
      end

      // A consumer draining the holder on the stop edge frees it for the new word.
      if (r_state == S_STOP) begin
        if (i_ser_in) begin
          if (!r_valid || w_consume) begin
            r_data  <= w_po;
            r_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign o_shift_en   = w_shift_en;
  assign o_busy       = r_busy;
  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

endmodule

`default_nettype wire
